// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Brief    : Hardwired control unit that steps fetch/decode/execute phases
//            T0..T5 for a register-register ALU instruction subset.
//            Optional macro MEM_WAIT_EN stretches T1 until mem_ready.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zlowout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [4:0]  alu_op,
    output logic        done,
    output logic        illegal,
    output logic [15:0] instr_count
);

    localparam logic [2:0] C_IDLE = 3'd0;
    localparam logic [2:0] C_T0   = 3'd1;
    localparam logic [2:0] C_T1   = 3'd2;
    localparam logic [2:0] C_T2   = 3'd3;
    localparam logic [2:0] C_T3   = 3'd4;
    localparam logic [2:0] C_T4   = 3'd5;
    localparam logic [2:0] C_T5   = 3'd6;

    localparam logic [4:0] C_OP_ADD = 5'b00011;
    localparam logic [4:0] C_OP_SUB = 5'b00100;
    localparam logic [4:0] C_OP_AND = 5'b00101;
    localparam logic [4:0] C_OP_OR  = 5'b00110;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [15:0] r_instr_count;
    logic [4:0]  w_opcode;
    logic        w_legal;
    logic        w_t1_advance;
    logic        w_retire;

    assign w_opcode = ir[31:27];
    assign w_retire = (r_state == C_T5);

`ifdef MEM_WAIT_EN
    logic w_unused;
    assign w_unused     = &{1'b0, ir[26:0]};
    assign w_t1_advance = mem_ready;
`else
    logic w_unused;
    assign w_unused     = &{1'b0, ir[26:0], mem_ready};
    assign w_t1_advance = 1'b1;
`endif

    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR: w_legal = 1'b1;
            default:                               w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Written every cycle so the count register always reflects its own sum.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_instr_count <= 16'h0000;
        end else begin
            r_instr_count <= r_instr_count + {15'd0, w_retire};
        end
    end

    assign instr_count = r_instr_count;

    always_comb begin
        w_next_state = C_IDLE;
        case (r_state)
            C_IDLE:  w_next_state = run ? C_T0 : C_IDLE;
            C_T0:    w_next_state = C_T1;
            C_T1:    w_next_state = w_t1_advance ? C_T2 : C_T1;
            C_T2:    w_next_state = C_T3;
            C_T3:    w_next_state = w_legal ? C_T4 : C_IDLE;
            C_T4:    w_next_state = C_T5;
            C_T5:    w_next_state = run ? C_T0 : C_IDLE;
            default: w_next_state = C_IDLE;
        endcase
    end

    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        Read    = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zlowin  = 1'b0;
        Zlowout = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        alu_op  = 5'b00000;
        done    = 1'b0;
        illegal = 1'b0;
        case (r_state)
            C_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            C_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            C_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            C_T3: begin
                if (w_legal) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            C_T4: begin
                Grc    = 1'b1;
                Rout   = 1'b1;
                Zlowin = 1'b1;
                alu_op = w_opcode;
            end
            C_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
                done    = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Brief    : Self-checking bench for control_sequencer; directed scenarios
//            followed by randomized stimulus against a step-script model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] ir;
    logic        mem_ready;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin;
    logic        Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, done, illegal;
    logic [4:0]  alu_op;
    logic [15:0] instr_count;
    logic [22:0] got_outs;

    control_sequencer dut (
        .clock       (clock),
        .clear       (clear),
        .run         (run),
        .ir          (ir),
        .mem_ready   (mem_ready),
        .PCout       (PCout),
        .PCin        (PCin),
        .IncPC       (IncPC),
        .MARin       (MARin),
        .MDRin       (MDRin),
        .MDRout      (MDRout),
        .Read        (Read),
        .IRin        (IRin),
        .Yin         (Yin),
        .Zlowin      (Zlowin),
        .Zlowout     (Zlowout),
        .Gra         (Gra),
        .Grb         (Grb),
        .Grc         (Grc),
        .Rin         (Rin),
        .Rout        (Rout),
        .alu_op      (alu_op),
        .done        (done),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    assign got_outs = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin,
                       Zlowin, Zlowout, Gra, Grb, Grc, Rin, Rout, done, illegal, alu_op};

`ifdef MEM_WAIT_EN
    localparam bit C_MEM_WAIT = 1'b1;
`else
    localparam bit C_MEM_WAIT = 1'b0;
`endif

    localparam logic [17:0] M_PCOUT   = 18'd1 << 17;
    localparam logic [17:0] M_PCIN    = 18'd1 << 16;
    localparam logic [17:0] M_INCPC   = 18'd1 << 15;
    localparam logic [17:0] M_MARIN   = 18'd1 << 14;
    localparam logic [17:0] M_MDRIN   = 18'd1 << 13;
    localparam logic [17:0] M_MDROUT  = 18'd1 << 12;
    localparam logic [17:0] M_READ    = 18'd1 << 11;
    localparam logic [17:0] M_IRIN    = 18'd1 << 10;
    localparam logic [17:0] M_YIN     = 18'd1 << 9;
    localparam logic [17:0] M_ZLOWIN  = 18'd1 << 8;
    localparam logic [17:0] M_ZLOWOUT = 18'd1 << 7;
    localparam logic [17:0] M_GRA     = 18'd1 << 6;
    localparam logic [17:0] M_GRB     = 18'd1 << 5;
    localparam logic [17:0] M_GRC     = 18'd1 << 4;
    localparam logic [17:0] M_RIN     = 18'd1 << 3;
    localparam logic [17:0] M_ROUT    = 18'd1 << 2;
    localparam logic [17:0] M_DONE    = 18'd1 << 1;
    localparam logic [17:0] M_ILLEGAL = 18'd1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit is_legal(input logic [4:0] op);
        return op inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
    endfunction

    // Expected strobes for phase step (-1 idle, 0..5 = T0..T5).
    function automatic logic [22:0] exp_outs(input int step, input logic [4:0] op);
        logic [17:0] s;
        logic [4:0]  a;
        s = '0;
        a = '0;
        case (step)
            0: s = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
            1: s = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
            2: s = M_MDROUT | M_IRIN;
            3: s = is_legal(op) ? (M_GRB | M_ROUT | M_YIN) : M_ILLEGAL;
            4: begin
                s = M_GRC | M_ROUT | M_ZLOWIN;
                a = op;
            end
            5: s = M_ZLOWOUT | M_GRA | M_RIN | M_DONE;
            default: s = '0;
        endcase
        return {s, a};
    endfunction

    // Reference model: current phase plus the remaining script of phases.
    int          m_step = -1;
    int          m_script[$];
    logic [15:0] m_count = 16'h0000;

    task automatic model_edge();
        if (clear) begin
            m_step  = -1;
            m_script.delete();
            m_count = 16'h0000;
        end else if (m_step == 1 && C_MEM_WAIT && !mem_ready) begin
            m_step = 1;
        end else begin
            if (m_step == 5) m_count = m_count + 16'd1;
            if (m_step == 3 && !is_legal(ir[31:27])) m_script.delete();
            if (m_script.size() > 0) begin
                m_step = m_script.pop_front();
            end else if (run && (m_step == -1 || m_step == 5)) begin
                m_step   = 0;
                m_script = '{1, 2, 3, 4, 5};
            end else begin
                m_step = -1;
            end
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clock);
        model_edge();
        #1;
        check({tag, ":outs"}, {9'd0, got_outs}, {9'd0, exp_outs(m_step, ir[31:27])});
        check({tag, ":count"}, {16'd0, instr_count}, {16'd0, m_count});
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 12 && m_step != -1; k++) cycle(tag);
        check({tag, ":drained"}, {9'd0, got_outs}, 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        int reads;
        logic [4:0] ops[4];
        ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110};

        clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'h0;
        cycle("reset");
        cycle("reset");
        check("reset_count", {16'd0, instr_count}, 32'd0);
        clear = 1'b0;

        // Single OR instruction
        ir = 32'h30918000; run = 1'b1;
        cycle("or");
        run = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            cycle("or");
            n++;
        end
        check("or_steps", n, 6);
        cycle("or");
        check("or_idle", {9'd0, got_outs}, 32'd0);
        check("or_count", {16'd0, instr_count}, 32'd1);

        // Unsupported opcode aborts after T3
        ir = 32'hF8000000; run = 1'b1;
        cycle("ill");
        run = 1'b0;
        n = 1;
        while (!illegal && n < 20) begin
            cycle("ill");
            n++;
        end
        check("ill_steps", n, 4);
        check("ill_t3_outs", {9'd0, got_outs}, {9'd0, M_ILLEGAL, 5'd0});
        cycle("ill");
        check("ill_idle", {9'd0, got_outs}, 32'd0);
        check("ill_count", {16'd0, instr_count}, 32'd1);

        // Back-to-back ADDs with run held
        clear = 1'b1;
        cycle("b2b");
        clear = 1'b0;
        ir = 32'h18918000; run = 1'b1;
        cycle("b2b");
        dones = 0;
        repeat (18) begin
            cycle("b2b");
            if (done) dones++;
        end
        check("b2b_dones", dones, 3);
        check("b2b_count", {16'd0, instr_count}, 32'd3);
        run = 1'b0;
        drain("b2b");

        // Clear during T4 abandons the instruction
        ir = 32'h30918000; run = 1'b1;
        cycle("clr");
        run = 1'b0;
        repeat (4) cycle("clr");
        check("clr_t4_alu", {27'd0, alu_op}, 32'd6);
        clear = 1'b1;
        cycle("clr");
        clear = 1'b0;
        check("clr_outs", {9'd0, got_outs}, 32'd0);
        check("clr_count", {16'd0, instr_count}, 32'd0);

        // T1 with mem_ready low for three T1 cycles
        ir = 32'h18918000; run = 1'b1; mem_ready = 1'b0;
        cycle("mw");
        run = 1'b0;
        reads = 0;
        n = 0;
        while (!done && n < 20) begin
            if (Read) reads++;
            mem_ready = (reads >= 4);
            cycle("mw");
            n++;
        end
        check("mw_t1_cycles", reads, C_MEM_WAIT ? 4 : 1);
        mem_ready = 1'b1;
        drain("mw");

        // Counter wrap: load 16'hFFFF then retire one more instruction
        force dut.r_instr_count = 16'hFFFF;
        m_count = 16'hFFFF;
        cycle("wrap_load");
        cycle("wrap_load");
        release dut.r_instr_count;
        cycle("wrap_pre");
        ir = 32'h20918000; run = 1'b1;
        cycle("wrap");
        run = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            cycle("wrap");
            n++;
        end
        cycle("wrap");
        check("wrap_count", {16'd0, instr_count}, 32'd0);

        // Randomized stimulus
        repeat (3000) begin
            run       = ($urandom_range(0, 9) < 6);
            mem_ready = ($urandom_range(0, 1) == 1);
            clear     = ($urandom_range(0, 99) < 2);
            if (m_step == -1 || m_step == 5) begin
                ir = $urandom;
                if ($urandom_range(0, 1) == 1) ir[31:27] = ops[$urandom_range(0, 3)];
            end
            cycle("rand");
        end
        clear = 1'b0; run = 1'b0; mem_ready = 1'b1;
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
